tamagotchi_controlador: RTL and testbench

- Central sequencer for the pet's need levels: a tick timebase, a decay scheduler per need, and a single-service arbiter for user actions.
- A life-state FSM (awake, asleep, sick, dead) gates which needs decay and which actions are accepted.
- Sits between the debounced button/sensor layer and the LED/display layer.
- Outputs 2-bit levels (0 = empty, 3 = full) plus the current state and test-mode flag.

---
 rtl/tamagotchi_controlador.sv | 180 ++++++++++++++++++
 tb/tb_tamagotchi_controlador.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_controlador.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tamagotchi_controlador: tick timebase, per-need decay scheduler,         |
// | single-service action arbiter and life-state FSM.       Rev 1.0          |
// +--------------------------------------------------------------------------+
module tamagotchi_controlador #(
  parameter int TICK_CYCLES = 50000000,
  parameter int DECAY_TICKS = 5,
  parameter int TEST_DIV    = 10
) (
  input  logic       clk,
  input  logic       Bot_Reset,
  input  logic       Bot_Test,
  input  logic       Bot_Energia,
  input  logic       Bot_Medicina,
  input  logic       Entrada_Animo,
  input  logic       Entrada_Descanso,
  output logic [1:0] Nivel_Energia,
  output logic [1:0] Nivel_Animo,
  output logic [1:0] Nivel_Descanso,
  output logic [1:0] Nivel_Salud,
  output logic [1:0] Estado,
  output logic       Modo_Test
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int DW = $clog2(DECAY_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST_NORM = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST_TEST = TW'(TICK_CYCLES / TEST_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST     = DW'(DECAY_TICKS - 1);

  // Button vector bits; the low three double as pending-flag indices.
  localparam int B_TEST = 3;
  localparam int P_MED  = 2;
  localparam int P_ENE  = 1;
  localparam int P_ANI  = 0;

  localparam int N_ENE = 0;
  localparam int N_ANI = 1;
  localparam int N_DES = 2;
  localparam int N_SAL = 3;

  typedef enum logic [1:0] {
    DESPIERTO = 2'd0,
    DORMIDO   = 2'd1,
    ENFERMO   = 2'd2,
    MUERTO    = 2'd3
  } estado_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? v : v - 2'd1;
  endfunction

  logic [3:0]         btn_in;
  logic [3:0]         btn_reg_q, btn_reg_d;
  logic [3:0]         btn_prev_q, btn_prev_d;
  logic [3:0]         pulse;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [TW-1:0]      tick_last;
  logic               modo_test_q, modo_test_d;
  logic [2:0]         pend_q, pend_d;
  logic [2:0]         accept, svc;
  logic [3:0][DW-1:0] dcnt_q, dcnt_d;
  logic [3:0][1:0]    lvl_q, lvl_d;
  logic [3:0]         cnt_en, step, svc_need;
  logic               alive, tick, sal_drop;
  estado_t            state_q, state_d;

  assign btn_in     = {Bot_Test, Bot_Medicina, Bot_Energia, Entrada_Animo};
  assign btn_reg_d  = btn_in;
  assign btn_prev_d = btn_reg_q;
  assign pulse      = btn_reg_q & ~btn_prev_q;
  assign alive      = (state_q != MUERTO);
  assign svc_need   = {svc[P_MED], 1'b0, svc[P_ANI], svc[P_ENE]};

  always_comb begin
    accept = 3'b000;
    case (state_q)
      DESPIERTO: accept = 3'b111;
      ENFERMO:   accept = 3'b100;
      default:   accept = 3'b000;
    endcase
    svc = 3'b000;
    if (pend_q[P_MED] && accept[P_MED])      svc[P_MED] = 1'b1;
    else if (pend_q[P_ENE] && accept[P_ENE]) svc[P_ENE] = 1'b1;
    else if (pend_q[P_ANI] && accept[P_ANI]) svc[P_ANI] = 1'b1;
    // Rejected flags drop immediately; losers stay pending for a later cycle.
    pend_d = (pend_q & accept & ~svc) | pulse[2:0];
  end

  always_comb begin
    modo_test_d = modo_test_q ^ pulse[B_TEST];
    tick_last   = modo_test_q ? TICK_LAST_TEST : TICK_LAST_NORM;
    tick        = alive && (tick_cnt_q == tick_last);
    if (pulse[B_TEST])  tick_cnt_d = '0;
    else if (!alive)    tick_cnt_d = tick_cnt_q;
    else if (tick)      tick_cnt_d = '0;
    else                tick_cnt_d = tick_cnt_q + TW'(1);

    cnt_en = {tick, tick, tick && (state_q != DORMIDO), tick};
    step   = '0;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 4; i++) begin
      step[i] = cnt_en[i] && (dcnt_q[i] == DECAY_LAST);
      if (svc_need[i] || step[i]) dcnt_d[i] = '0;
      else if (cnt_en[i])         dcnt_d[i] = dcnt_q[i] + DW'(1);
    end

    sal_drop = step[N_SAL] && !svc_need[N_SAL] &&
               ((lvl_q[N_ENE] == 2'd0) || (lvl_q[N_DES] == 2'd0));

    lvl_d = lvl_q;
    if (svc_need[N_ENE])   lvl_d[N_ENE] = sat_inc(lvl_q[N_ENE]);
    else if (step[N_ENE])  lvl_d[N_ENE] = sat_dec(lvl_q[N_ENE]);
    if (svc_need[N_ANI])   lvl_d[N_ANI] = sat_inc(lvl_q[N_ANI]);
    else if (step[N_ANI])  lvl_d[N_ANI] = sat_dec(lvl_q[N_ANI]);
    if (step[N_DES])       lvl_d[N_DES] = (state_q == DORMIDO) ? sat_inc(lvl_q[N_DES])
                                                               : sat_dec(lvl_q[N_DES]);
    if (svc_need[N_SAL])   lvl_d[N_SAL] = sat_inc(lvl_q[N_SAL]);
    else if (sal_drop)     lvl_d[N_SAL] = sat_dec(lvl_q[N_SAL]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DESPIERTO: begin
        if (lvl_q[N_SAL] <= 2'd1)                           state_d = ENFERMO;
        else if (Entrada_Descanso && lvl_q[N_DES] != 2'd3)  state_d = DORMIDO;
      end
      DORMIDO: begin
        if (lvl_q[N_SAL] <= 2'd1)                           state_d = ENFERMO;
        else if (!Entrada_Descanso || lvl_q[N_DES] == 2'd3) state_d = DESPIERTO;
      end
      ENFERMO: begin
        // Death coincides with the Salud step that empties the level.
        if (sal_drop && lvl_q[N_SAL] == 2'd1)               state_d = MUERTO;
        else if (lvl_q[N_SAL] == 2'd3)                      state_d = DESPIERTO;
      end
      default:                                              state_d = MUERTO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Bot_Reset) state_q <= DESPIERTO;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (Bot_Reset) begin
      btn_reg_q   <= '0;
      btn_prev_q  <= '0;
      tick_cnt_q  <= '0;
      modo_test_q <= 1'b0;
      pend_q      <= '0;
      dcnt_q      <= '0;
      lvl_q       <= {4{2'd3}};
    end else begin
      btn_reg_q   <= btn_reg_d;
      btn_prev_q  <= btn_prev_d;
      tick_cnt_q  <= tick_cnt_d;
      modo_test_q <= modo_test_d;
      pend_q      <= pend_d;
      dcnt_q      <= dcnt_d;
      lvl_q       <= lvl_d;
    end
  end

  assign Nivel_Energia  = lvl_q[N_ENE];
  assign Nivel_Animo    = lvl_q[N_ANI];
  assign Nivel_Descanso = lvl_q[N_DES];
  assign Nivel_Salud    = lvl_q[N_SAL];
  assign Estado         = state_q;
  assign Modo_Test      = modo_test_q;

endmodule
`default_nettype wire

// File: tb/tb_tamagotchi_controlador.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tamagotchi_controlador: directed bench, TICK_CYCLES=4, DECAY_TICKS=2, |
// | TEST_DIV=2; edges counted from the reset-release edge.   Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_tamagotchi_controlador;

  logic       clk;
  logic       Bot_Reset;
  logic       Bot_Test;
  logic       Bot_Energia;
  logic       Bot_Medicina;
  logic       Entrada_Animo;
  logic       Entrada_Descanso;
  logic [1:0] Nivel_Energia;
  logic [1:0] Nivel_Animo;
  logic [1:0] Nivel_Descanso;
  logic [1:0] Nivel_Salud;
  logic [1:0] Estado;
  logic       Modo_Test;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tamagotchi_controlador #(
    .TICK_CYCLES(4),
    .DECAY_TICKS(2),
    .TEST_DIV   (2)
  ) dut (
    .clk             (clk),
    .Bot_Reset       (Bot_Reset),
    .Bot_Test        (Bot_Test),
    .Bot_Energia     (Bot_Energia),
    .Bot_Medicina    (Bot_Medicina),
    .Entrada_Animo   (Entrada_Animo),
    .Entrada_Descanso(Entrada_Descanso),
    .Nivel_Energia   (Nivel_Energia),
    .Nivel_Animo     (Nivel_Animo),
    .Nivel_Descanso  (Nivel_Descanso),
    .Nivel_Salud     (Nivel_Salud),
    .Estado          (Estado),
    .Modo_Test       (Modo_Test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic lv(input string tag, input logic [1:0] e, input logic [1:0] a,
                    input logic [1:0] d, input logic [1:0] s);
    chk({tag, ".ene"}, Nivel_Energia, e);
    chk({tag, ".ani"}, Nivel_Animo, a);
    chk({tag, ".des"}, Nivel_Descanso, d);
    chk({tag, ".sal"}, Nivel_Salud, s);
  endtask

  // Advance to a given edge count, sampling 1 time unit after that edge.
  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    Bot_Reset = 1'b1;
    @(posedge clk);
    #1;
    Bot_Reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    Bot_Reset = 1'b0; Bot_Test = 1'b0; Bot_Energia = 1'b0; Bot_Medicina = 1'b0;
    Entrada_Animo = 1'b0; Entrada_Descanso = 1'b0;
    @(negedge clk);

    // Reset values and idle decay, then starvation to death.
    do_reset();
    lv("rst", 2'd3, 2'd3, 2'd3, 2'd3);
    chk("rst.estado", Estado, 2'd0);
    chk("rst.modo", {1'b0, Modo_Test}, 2'd0);
    adv_to(7);  chk("e7.ene", Nivel_Energia, 2'd3);
    adv_to(8);  lv("e8", 2'd2, 2'd2, 2'd2, 2'd3);
    adv_to(16); lv("e16", 2'd1, 2'd1, 2'd1, 2'd3);
    adv_to(24); lv("e24", 2'd0, 2'd0, 2'd0, 2'd3);
    chk("e24.estado", Estado, 2'd0);
    adv_to(32); chk("e32.sal", Nivel_Salud, 2'd2);
    adv_to(40); chk("e40.sal", Nivel_Salud, 2'd1);
    chk("e40.estado", Estado, 2'd0);
    adv_to(41); chk("e41.estado_enfermo", Estado, 2'd2);
    Bot_Energia = 1'b1;
    adv_to(46); chk("enfermo.ene_rejected", Nivel_Energia, 2'd0);
    chk("e46.sal", Nivel_Salud, 2'd1);
    Bot_Energia = 1'b0;
    adv_to(48); chk("e48.sal_zero", Nivel_Salud, 2'd0);
    adv_to(49); chk("e49.estado_muerto", Estado, 2'd3);
    Bot_Medicina = 1'b1; Bot_Energia = 1'b1; Entrada_Animo = 1'b1;
    Bot_Test = 1'b1; Entrada_Descanso = 1'b1;
    adv_to(52);
    Bot_Medicina = 1'b0; Bot_Energia = 1'b0; Entrada_Animo = 1'b0;
    Bot_Test = 1'b0; Entrada_Descanso = 1'b0;
    adv_to(60); lv("muerto.frozen", 2'd0, 2'd0, 2'd0, 2'd0);
    chk("muerto.estado", Estado, 2'd3);
    chk("muerto.modo_toggle", {1'b0, Modo_Test}, 2'd1);
    do_reset();
    lv("rst2", 2'd3, 2'd3, 2'd3, 2'd3);
    chk("rst2.estado", Estado, 2'd0);
    chk("rst2.modo", {1'b0, Modo_Test}, 2'd0);

    // Simultaneous Medicina + Energia: Medicina first, one more cycle for Energia.
    adv_to(32); chk("b32.sal", Nivel_Salud, 2'd2);
    chk("b32.ene", Nivel_Energia, 2'd0);
    chk("b32.estado", Estado, 2'd0);
    Bot_Medicina = 1'b1; Bot_Energia = 1'b1;
    adv_to(34); chk("b34.sal", Nivel_Salud, 2'd2);
    chk("b34.ene", Nivel_Energia, 2'd0);
    adv_to(35); chk("b35.sal", Nivel_Salud, 2'd3);
    chk("b35.ene", Nivel_Energia, 2'd0);
    adv_to(36); chk("b36.sal", Nivel_Salud, 2'd3);
    chk("b36.ene", Nivel_Energia, 2'd1);
    adv_to(39); chk("b39.held_sal", Nivel_Salud, 2'd3);
    chk("b39.held_ene", Nivel_Energia, 2'd1);
    Bot_Medicina = 1'b0; Bot_Energia = 1'b0;
    Entrada_Animo = 1'b1;
    adv_to(41); chk("b41.ani", Nivel_Animo, 2'd0);
    adv_to(42); chk("b42.ani_play", Nivel_Animo, 2'd1);
    Entrada_Animo = 1'b0;
    do_reset();

    // Sleep: feeding ignored, Animo paused, Descanso recovers, wake at full rest.
    adv_to(16); chk("c16.des", Nivel_Descanso, 2'd1);
    chk("c16.estado", Estado, 2'd0);
    Entrada_Descanso = 1'b1;
    adv_to(17); chk("c17.estado_dormido", Estado, 2'd1);
    Bot_Energia = 1'b1;
    adv_to(19);
    Bot_Energia = 1'b0;
    adv_to(22); chk("dormido.ene_rejected", Nivel_Energia, 2'd1);
    adv_to(24); lv("c24", 2'd0, 2'd1, 2'd2, 2'd3);
    chk("c24.estado", Estado, 2'd1);
    adv_to(32); chk("c32.ani_paused", Nivel_Animo, 2'd1);
    chk("c32.des_full", Nivel_Descanso, 2'd3);
    chk("c32.estado", Estado, 2'd1);
    adv_to(33); chk("c33.estado_wake", Estado, 2'd0);
    adv_to(34); chk("c34.estado_stay_awake", Estado, 2'd0);
    Entrada_Descanso = 1'b0;
    do_reset();

    // Test mode: 2-cycle ticks, 4-cycle decay; toggling back restores 4-cycle ticks.
    Bot_Test = 1'b1;
    adv_to(1);  chk("d1.modo", {1'b0, Modo_Test}, 2'd0);
    adv_to(2);  chk("d2.modo", {1'b0, Modo_Test}, 2'd1);
    adv_to(3);
    Bot_Test = 1'b0;
    adv_to(5);  chk("d5.ene", Nivel_Energia, 2'd3);
    adv_to(6);  chk("d6.ene_fast", Nivel_Energia, 2'd2);
    adv_to(9);  chk("d9.ene", Nivel_Energia, 2'd2);
    adv_to(10); chk("d10.ene_fast", Nivel_Energia, 2'd1);
    adv_to(11);
    Bot_Test = 1'b1;
    adv_to(13); chk("d13.modo_off", {1'b0, Modo_Test}, 2'd0);
    adv_to(14);
    Bot_Test = 1'b0;
    adv_to(16); chk("d16.ene_slow", Nivel_Energia, 2'd1);
    adv_to(17); chk("d17.ene", Nivel_Energia, 2'd0);
    do_reset();

    // Reset while a Medicina request is pending in ENFERMO.
    adv_to(41); chk("f41.estado", Estado, 2'd2);
    Bot_Medicina = 1'b1;
    adv_to(42);
    Bot_Medicina = 1'b0;
    do_reset();
    lv("f.rst", 2'd3, 2'd3, 2'd3, 2'd3);
    chk("f.rst.estado", Estado, 2'd0);
    adv_to(7);  chk("f7.ene", Nivel_Energia, 2'd3);
    chk("f7.sal", Nivel_Salud, 2'd3);
    adv_to(8);  chk("f8.ene", Nivel_Energia, 2'd2);
    chk("f8.estado", Estado, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
